spi_slave: RTL

- Oversampled SPI responder: the target-side counterpart of the SoC SPI master (sclk/nss/mosi driven externally, miso driven here).
- Samples the external pins in the clk domain and deserialises MSB-first frames into a valid/ready byte stream.
- Serialises a valid/ready transmit stream onto miso.
- Used for board-to-board links and as the loopback responder in SPI master verification.

---
 rtl/spi_pkg.sv | 17 +
 rtl/sync_cell.sv | 24 ++
 rtl/spi_slave.sv | 117 +++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encoding, sample-edge helper and default idle fill.
package spi_pkg;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Bit value replicated across the frame width when the transmit stream runs dry.
  localparam logic IDLE_FILL_BIT = 1'b1;

  // Data is sampled on the rising sclk edge when CPOL and CPHA agree.
  function automatic logic sample_on_rise(input spi_mode_t m);
    return ~(m.cpol ^ m.cpha);
  endfunction

endpackage

// File: rtl/sync_cell.sv
// Multi-flop synchroniser for one asynchronous pin, with a configurable reset value.
module sync_cell #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI target: pins are synchronised into clk, frames are deserialised
// into a valid/ready rx stream and a valid/ready tx stream is serialised onto miso.
module spi_slave
  import spi_pkg::*;
#(
  parameter int              DW          = 8,
  parameter int              SYNC_STAGES = 2,
  parameter logic [DW-1:0]   IDLE_FILL   = {DW{IDLE_FILL_BIT}}
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [1:0]    cfg_mode,
  input  logic          sclk,
  input  logic          nss,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          rx_overrun,
  output logic          tx_underrun,
  output logic          frame_abort,
  output logic          busy
);

  localparam int CW = $clog2(DW);

  logic          s_sclk, s_nss, s_mosi;
  logic          sclk_q, nss_q;
  spi_mode_t     mode_q, cfg_m;
  logic [CW-1:0] bit_cnt;
  logic [DW-2:0] rx_shift;
  logic [DW-1:0] rx_next, tx_shift;
  logic          nss_fall, nss_rise, sclk_rise, sclk_fall, in_frame;
  logic          sample_edge, shift_edge, byte_done, load_now, rx_free;

  sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rstn(rstn), .d(sclk), .q(s_sclk)
  );
  sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nss (
    .clk(clk), .rstn(rstn), .d(nss), .q(s_nss)
  );
  sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rstn(rstn), .d(mosi), .q(s_mosi)
  );

  assign cfg_m     = spi_mode_t'(cfg_mode);
  assign nss_fall  = nss_q & ~s_nss;
  assign nss_rise  = ~nss_q & s_nss;
  assign sclk_rise = s_sclk & ~sclk_q;
  assign sclk_fall = ~s_sclk & sclk_q;
  // The frame-start cycle itself carries no sclk event; edges count only once settled low.
  assign in_frame  = ~s_nss & ~nss_q;

  assign sample_edge = in_frame & (sample_on_rise(mode_q) ? sclk_rise : sclk_fall);
  assign shift_edge  = in_frame & (sample_on_rise(mode_q) ? sclk_fall : sclk_rise);
  assign byte_done   = sample_edge & (bit_cnt == CW'(DW-1));
  assign load_now    = (nss_fall & ~cfg_m.cpha) | (shift_edge & (bit_cnt == '0));
  assign rx_next     = {rx_shift, s_mosi};

  // Handshakes: a word transfers on any clk edge where valid and ready are both high.
  // rx_valid holds rx_data stable until accepted; tx_ready is high only in the single
  // cycle a load takes place, so tx_data is consumed exactly when tx_valid&tx_ready.
  assign rx_free     = ~rx_valid | rx_ready;
  assign tx_ready    = rstn & load_now & tx_valid;
  assign tx_underrun = rstn & load_now & ~tx_valid;
  assign rx_overrun  = rstn & byte_done & ~rx_free;
  assign frame_abort = rstn & nss_rise & (bit_cnt != '0);

  assign busy    = ~s_nss;
  assign miso_oe = busy;
  assign miso    = busy ? tx_shift[DW-1] : 1'b1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sclk_q   <= 1'b0;
      nss_q    <= 1'b1;
      mode_q   <= '0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      sclk_q <= s_sclk;
      nss_q  <= s_nss;

      if (nss_fall) begin
        mode_q  <= cfg_m;
        bit_cnt <= '0;
      end else if (nss_rise) begin
        bit_cnt <= '0;
      end else if (sample_edge) begin
        rx_shift <= rx_next[DW-2:0];
        bit_cnt  <= byte_done ? '0 : bit_cnt + CW'(1);
      end

      if (load_now) begin
        tx_shift <= tx_valid ? tx_data : IDLE_FILL;
      end else if (shift_edge) begin
        tx_shift <= {tx_shift[DW-2:0], 1'b0};
      end

      if (byte_done && rx_free) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
